// File: rtl/dmem_unit.sv
// dmem_unit: data-memory stage behind the ALU. Byte/half/word loads and
// stores against an internal RAM with a fixed wait-state latency.
// Optional build macro DMEM_MISALIGN_TRAP_EN: when defined, misaligned
// H/HU/W accesses are suppressed and flagged on `misaligned`; when not
// defined, low address bits are truncated to natural alignment.
module dmem_unit #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        mem_write,
  input  logic [2:0]  mem_funct3,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        mem_stall,
  output logic        misaligned
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        write_q, write_d;

  logic [1:0]    size;
  logic          invalid;
  logic          mis;
  logic [31:0]   eff_addr;
  logic [AW-1:0] word_idx;
  logic          access;
  logic [3:0]    byte_en;
  logic [31:0]   wlane;
  logic [31:0]   ram_word;
  logic [31:0]   shifted;
  logic [31:0]   load_data;

  // State and holding registers; aborted accesses simply return to IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      write_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      write_q  <= write_d;
    end
  end

  // Next-state logic: capture request in IDLE, count wait states, one RESP cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;
    write_d  = write_q;
    case (state_q)
      IDLE: begin
        if (mem_req) begin
          addr_d   = mem_addr;
          wdata_d  = mem_wdata;
          funct3_d = mem_funct3;
          write_d  = mem_write;
          cnt_d    = 4'(WAIT_CYCLES);
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Decode the held access: size, legality, aligned address and byte enables.
  always_comb begin
    size    = funct3_q[1:0];
    invalid = (funct3_q == 3'b011) || (funct3_q[2:1] == 2'b11);
`ifdef DMEM_MISALIGN_TRAP_EN
    mis = !invalid && (((size == 2'b01) && addr_q[0]) ||
                       ((size == 2'b10) && (addr_q[1:0] != 2'b00)));
`else
    mis = 1'b0;
`endif
    case (size)
      2'b01:   eff_addr = {addr_q[31:1], 1'b0};
      2'b10:   eff_addr = {addr_q[31:2], 2'b00};
      default: eff_addr = addr_q;
    endcase
    word_idx = eff_addr[2 +: AW];
    access   = (state_q == WAIT) && (cnt_q == 4'd0);
    byte_en  = 4'b0000;
    if (write_q && !invalid && !mis) begin
      case (size)
        2'b00:   byte_en = 4'b0001 << eff_addr[1:0];
        2'b01:   byte_en = eff_addr[1] ? 4'b1100 : 4'b0011;
        2'b10:   byte_en = 4'b1111;
        default: byte_en = 4'b0000;
      endcase
    end
    case (size)
      2'b00:   wlane = {4{wdata_q[7:0]}};
      2'b01:   wlane = {2{wdata_q[15:0]}};
      default: wlane = wdata_q;
    endcase
  end

  // One RAM bank per byte lane, so byte-enabled writes map onto plain block RAM.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bank
      logic [7:0] bank [DEPTH_WORDS];
      logic [7:0] rd_byte_q;

      // Registered read and byte write on the access edge only.
      always_ff @(posedge clk) begin
        if (access) begin
          rd_byte_q <= bank[word_idx];
          if (byte_en[gi]) bank[word_idx] <= wlane[gi*8 +: 8];
        end
      end

      assign ram_word[gi*8 +: 8] = rd_byte_q;
    end
  endgenerate

  // Lane select and sign/zero extension of the registered read word.
  always_comb begin
    shifted   = ram_word >> {eff_addr[1:0], 3'b000};
    load_data = 32'd0;
    case (size)
      2'b00:   load_data = funct3_q[2] ? {24'd0, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_data = funct3_q[2] ? {16'd0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
      2'b10:   load_data = ram_word;
      default: load_data = 32'd0;
    endcase
    if (write_q || invalid || mis) load_data = 32'd0;
  end

  // Outputs are only meaningful in RESP; stall is forced low while in reset.
  always_comb begin
    mem_ready  = (state_q == RESP);
    mem_rdata  = mem_ready ? load_data : 32'd0;
    misaligned = mem_ready && mis;
    mem_stall  = !reset && (((state_q == IDLE) && mem_req) || (state_q == WAIT));
  end

endmodule

// File: tb/tb_dmem_unit.sv
// tb_dmem_unit: directed table-driven bench for dmem_unit (default parameters).
module tb_dmem_unit;

  localparam int W = 2;

`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req;
  logic        mem_write;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        mem_stall;
  logic        misaligned;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    logic        exp_mis;
  } vec_t;

  vec_t vq[$];

  dmem_unit #(.DEPTH_WORDS(1024), .WAIT_CYCLES(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_req    (mem_req),
    .mem_write  (mem_write),
    .mem_funct3 (mem_funct3),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .mem_stall  (mem_stall),
    .misaligned (misaligned)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, got, exp);
    end
  endtask

  // One request: issued in an IDLE cycle, held until the RESP cycle is sampled.
  task automatic run_access(input int idx, input vec_t v);
    int   ready_cyc;
    logic stall_ok;
    @(negedge clk);
    mem_req    = 1'b1;
    mem_write  = v.wr;
    mem_funct3 = v.f3;
    mem_addr   = v.addr;
    mem_wdata  = v.wdata;
    #1;
    check("idle_rdata", idx, mem_rdata, 32'd0);
    stall_ok  = mem_stall && !mem_ready;
    ready_cyc = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (mem_ready) begin
        ready_cyc = k;
        break;
      end
      if (!mem_stall) stall_ok = 1'b0;
    end
    if (ready_cyc > 0 && mem_stall) stall_ok = 1'b0;
    check("latency", idx, 32'(ready_cyc), 32'(W + 2));
    check("stall", idx, {31'd0, stall_ok}, 32'd1);
    check("rdata", idx, mem_rdata, v.exp);
    check("misaligned", idx, {31'd0, misaligned}, {31'd0, v.exp_mis});
    $display("txn %0d: %s f3=%b addr=%h wdata=%h -> rdata=%h mis=%b lat=%0d",
             idx, v.wr ? "ST" : "LD", v.f3, v.addr, v.wdata, mem_rdata, misaligned, ready_cyc);
  endtask

  initial begin
    // Stimulus table: {write, funct3, addr, wdata, expected rdata, expected misaligned}
    vq.push_back('{1'b1, 3'b010, 32'h0000_0040, 32'h1111_1111, 32'h0, 1'b0});
    vq.push_back('{1'b1, 3'b010, 32'h0000_0100, 32'h1234_5678, 32'h0, 1'b0});
    vq.push_back('{1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'h1234_5678, 1'b0});
    vq.push_back('{1'b1, 3'b000, 32'h0000_0103, 32'hAAAA_AA80, 32'h0, 1'b0});
    vq.push_back('{1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'hFFFF_FF80, 1'b0});
    vq.push_back('{1'b0, 3'b100, 32'h0000_0103, 32'h0, 32'h0000_0080, 1'b0});
    vq.push_back('{1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'h8034_5678, 1'b0});
    vq.push_back('{1'b1, 3'b001, 32'h0000_0102, 32'h1111_BEEF, 32'h0, 1'b0});
    vq.push_back('{1'b0, 3'b001, 32'h0000_0102, 32'h0, 32'hFFFF_BEEF, 1'b0});
    vq.push_back('{1'b0, 3'b101, 32'h0000_0102, 32'h0, 32'h0000_BEEF, 1'b0});
    vq.push_back('{1'b0, 3'b011, 32'h0000_0100, 32'h0, 32'h0, 1'b0});
    vq.push_back('{1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hBEEF_5678, 1'b0});
    vq.push_back('{1'b1, 3'b111, 32'h0000_0100, 32'hFFFF_FFFF, 32'h0, 1'b0});
    vq.push_back('{1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hBEEF_5678, 1'b0});
    vq.push_back('{1'b0, 3'b000, 32'h0000_0101, 32'h0, 32'h0000_0056, 1'b0});
    vq.push_back('{1'b0, 3'b000, 32'h0000_0102, 32'h0, 32'hFFFF_FFEF, 1'b0});
    vq.push_back('{1'b0, 3'b001, 32'h0000_0100, 32'h0, 32'h0000_5678, 1'b0});
    vq.push_back('{1'b1, 3'b010, 32'h0000_1000, 32'hCAFE_F00D, 32'h0, 1'b0});
    vq.push_back('{1'b0, 3'b010, 32'h0000_0000, 32'h0, 32'hCAFE_F00D, 1'b0});
    vq.push_back('{1'b1, 3'b010, 32'h0000_0102, 32'h0BAD_F00D, 32'h0, TRAP});
    vq.push_back('{1'b0, 3'b010, 32'h0000_0102, 32'h0,
                   TRAP ? 32'h0 : 32'h0BAD_F00D, TRAP});
    vq.push_back('{1'b0, 3'b010, 32'h0000_0100, 32'h0,
                   TRAP ? 32'hBEEF_5678 : 32'h0BAD_F00D, 1'b0});
    vq.push_back('{1'b0, 3'b001, 32'h0000_0103, 32'h0,
                   TRAP ? 32'h0 : 32'h0000_0BAD, TRAP});
    vq.push_back('{1'b0, 3'b101, 32'h0000_0101, 32'h0,
                   TRAP ? 32'h0 : 32'h0000_F00D, TRAP});

    reset      = 1'b1;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    mem_funct3 = 3'b010;
    mem_addr   = 32'h0;
    mem_wdata  = 32'h0;

    // Outputs held at zero in reset, even with a request present.
    repeat (2) @(negedge clk);
    mem_req = 1'b1;
    #1;
    check("rst_rdata", 0, mem_rdata, 32'd0);
    check("rst_ready", 0, {31'd0, mem_ready}, 32'd0);
    check("rst_stall", 0, {31'd0, mem_stall}, 32'd0);
    check("rst_mis", 0, {31'd0, misaligned}, 32'd0);
    mem_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // Directed table, issued back to back at minimum spacing.
    foreach (vq[i]) run_access(i, vq[i]);

    // Reset in the middle of WAIT for a store: outputs drop, store is lost.
    @(negedge clk);
    mem_req    = 1'b1;
    mem_write  = 1'b1;
    mem_funct3 = 3'b010;
    mem_addr   = 32'h0000_0040;
    mem_wdata  = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_rdata", 1, mem_rdata, 32'd0);
    check("midrst_ready", 1, {31'd0, mem_ready}, 32'd0);
    check("midrst_stall", 1, {31'd0, mem_stall}, 32'd0);
    check("midrst_mis", 1, {31'd0, misaligned}, 32'd0);
    mem_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    run_access(100, '{1'b0, 3'b010, 32'h0000_0040, 32'h0, 32'h1111_1111, 1'b0});

    @(negedge clk);
    mem_req = 1'b0;
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
